// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter
//   Two-master Wishbone arbiter (instruction master I, data master D) in front
//   of one shared slave. Grants are round-robin on ties, held for the whole
//   cycle once given (no preemption), and handed over directly to a waiting
//   master when the owner drops cyc. A granted strobe that goes TIMEOUT cycles
//   without an ack is aborted: one ABORT cycle that raises err_o to the owner.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-low reset
//   wbm_i_*                      instruction master (read-only)
//   wbm_d_*                      data master (read/write)
//   wbs_*                        shared slave bus
//   grant_o                      one-hot owner: 01 = I, 10 = D, 00 = none
module wb_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // instruction master
  input  logic [31:0] wbm_i_adr_i,
  input  logic        wbm_i_cyc_i,
  input  logic        wbm_i_stb_i,
  output logic [15:0] wbm_i_dat_o,
  output logic        wbm_i_ack_o,
  output logic        wbm_i_err_o,
  // data master
  input  logic [31:0] wbm_d_adr_i,
  input  logic [15:0] wbm_d_dat_i,
  input  logic [1:0]  wbm_d_sel_i,
  input  logic        wbm_d_we_i,
  input  logic        wbm_d_cyc_i,
  input  logic        wbm_d_stb_i,
  output logic [15:0] wbm_d_dat_o,
  output logic        wbm_d_ack_o,
  output logic        wbm_d_err_o,
  // shared slave
  output logic [31:0] wbs_adr_o,
  output logic [15:0] wbs_dat_o,
  output logic [1:0]  wbs_sel_o,
  output logic        wbs_we_o,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  input  logic [15:0] wbs_dat_i,
  input  logic        wbs_ack_i,
  // owner
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2,
    ABORT = 2'd3
  } state_t;

  // Counter value on the last cycle a strobe may wait; reaching it with no
  // ack means the next edge aborts.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_owner_q, last_owner_d;  // 0 = I, 1 = D
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        own_stb;
  logic        timed_out;

  assign own_stb   = (state_q == OWN_I) ? wbm_i_stb_i :
                     (state_q == OWN_D) ? wbm_d_stb_i : 1'b0;
  // Ack wins over a timeout landing in the same cycle.
  assign timed_out = own_stb && !wbs_ack_i && (wait_cnt_q == WAIT_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    wait_cnt_d   = wait_cnt_q;

    case (state_q)
      IDLE: begin
        if (wbm_i_cyc_i && wbm_d_cyc_i) state_d = last_owner_q ? OWN_I : OWN_D;
        else if (wbm_i_cyc_i)           state_d = OWN_I;
        else if (wbm_d_cyc_i)           state_d = OWN_D;
      end
      OWN_I: begin
        if (!wbm_i_cyc_i)   state_d = wbm_d_cyc_i ? OWN_D : IDLE;
        else if (timed_out) state_d = ABORT;
      end
      OWN_D: begin
        if (!wbm_d_cyc_i)   state_d = wbm_i_cyc_i ? OWN_I : IDLE;
        else if (timed_out) state_d = ABORT;
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Entry into an OWN state (including a direct I<->D handover) restarts
    // the wait count and records the new owner for round-robin.
    if ((state_d == OWN_I || state_d == OWN_D) && state_d != state_q) begin
      wait_cnt_d   = '0;
      last_owner_d = (state_d == OWN_D);
    end else if (state_q == OWN_I || state_q == OWN_D) begin
      if (wbs_ack_i || !own_stb) wait_cnt_d = '0;
      else                       wait_cnt_d = wait_cnt_q + 16'd1;
    end else begin
      wait_cnt_d = '0;
    end
  end

  // Slave-side mux and master responses. In ABORT, last_owner still names
  // the master that was just aborted, so it steers err_o.
  always_comb begin
    wbs_adr_o   = '0;
    wbs_dat_o   = '0;
    wbs_sel_o   = '0;
    wbs_we_o    = 1'b0;
    wbs_cyc_o   = 1'b0;
    wbs_stb_o   = 1'b0;
    wbm_i_ack_o = 1'b0;
    wbm_d_ack_o = 1'b0;
    wbm_i_err_o = 1'b0;
    wbm_d_err_o = 1'b0;
    grant_o     = 2'b00;

    case (state_q)
      OWN_I: begin
        wbs_adr_o   = wbm_i_adr_i;
        wbs_sel_o   = 2'b11;
        wbs_cyc_o   = wbm_i_cyc_i;
        wbs_stb_o   = wbm_i_stb_i;
        wbm_i_ack_o = wbs_ack_i;
        grant_o     = 2'b01;
      end
      OWN_D: begin
        wbs_adr_o   = wbm_d_adr_i;
        wbs_dat_o   = wbm_d_dat_i;
        wbs_sel_o   = wbm_d_sel_i;
        wbs_we_o    = wbm_d_we_i;
        wbs_cyc_o   = wbm_d_cyc_i;
        wbs_stb_o   = wbm_d_stb_i;
        wbm_d_ack_o = wbs_ack_i;
        grant_o     = 2'b10;
      end
      ABORT: begin
        wbm_i_err_o = !last_owner_q;
        wbm_d_err_o = last_owner_q;
      end
      default: ;
    endcase
  end

  assign wbm_i_dat_o = wbs_dat_i;
  assign wbm_d_dat_o = wbs_dat_i;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter
//   Directed bench for wb_bus_arbiter (TIMEOUT = 4). Stimulus pushes every
//   expected master response (ack/err and returned data) into a scoreboard;
//   a negedge monitor pops one entry for each response the DUT raises.
//   Grant and slave-bus values are checked inline by the stimulus.
module tb_wb_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] wbm_i_adr_i;
  logic        wbm_i_cyc_i, wbm_i_stb_i;
  logic [15:0] wbm_i_dat_o;
  logic        wbm_i_ack_o, wbm_i_err_o;
  logic [31:0] wbm_d_adr_i;
  logic [15:0] wbm_d_dat_i;
  logic [1:0]  wbm_d_sel_i;
  logic        wbm_d_we_i, wbm_d_cyc_i, wbm_d_stb_i;
  logic [15:0] wbm_d_dat_o;
  logic        wbm_d_ack_o, wbm_d_err_o;
  logic [31:0] wbs_adr_o;
  logic [15:0] wbs_dat_o;
  logic [1:0]  wbs_sel_o;
  logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [15:0] wbs_dat_i;
  logic        wbs_ack_i;
  logic [1:0]  grant_o;

  wb_bus_arbiter #(.TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wbm_i_adr_i(wbm_i_adr_i), .wbm_i_cyc_i(wbm_i_cyc_i), .wbm_i_stb_i(wbm_i_stb_i),
    .wbm_i_dat_o(wbm_i_dat_o), .wbm_i_ack_o(wbm_i_ack_o), .wbm_i_err_o(wbm_i_err_o),
    .wbm_d_adr_i(wbm_d_adr_i), .wbm_d_dat_i(wbm_d_dat_i), .wbm_d_sel_i(wbm_d_sel_i),
    .wbm_d_we_i(wbm_d_we_i), .wbm_d_cyc_i(wbm_d_cyc_i), .wbm_d_stb_i(wbm_d_stb_i),
    .wbm_d_dat_o(wbm_d_dat_o), .wbm_d_ack_o(wbm_d_ack_o), .wbm_d_err_o(wbm_d_err_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  // Response vector: {I ack, D ack, I err, D err}
  localparam logic [3:0] R_ACK_I = 4'b1000;
  localparam logic [3:0] R_ACK_D = 4'b0100;
  localparam logic [3:0] R_ERR_D = 4'b0001;

  typedef struct packed {
    logic [3:0]  resp;
    logic [15:0] dat;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   done   = 1'b0;

  logic [3:0] resp_now;
  assign resp_now = {wbm_i_ack_o, wbm_d_ack_o, wbm_i_err_o, wbm_d_err_o};

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [3:0] r, input logic [15:0] d);
    exp_t e;
    e.resp = r;
    e.dat  = d;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: every asserted response must match the next scoreboard entry.
  always @(negedge clk_i) begin
    exp_t        e;
    logic [15:0] dat_act;
    if (!done && resp_now != 4'b0000) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_resp got=%b want=none", resp_now);
      end else begin
        e       = sb.pop_front();
        dat_act = resp_now[3] ? wbm_i_dat_o : wbm_d_dat_o;
        if (resp_now !== e.resp || ((e.resp[3] || e.resp[2]) && dat_act !== e.dat)) begin
          n_miss++;
          $display("FAIL sb_resp got=%b/%h want=%b/%h", resp_now, dat_act, e.resp, e.dat);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    wbm_i_adr_i = '0; wbm_i_cyc_i = 1'b0; wbm_i_stb_i = 1'b0;
    wbm_d_adr_i = '0; wbm_d_dat_i = '0; wbm_d_sel_i = '0;
    wbm_d_we_i = 1'b0; wbm_d_cyc_i = 1'b0; wbm_d_stb_i = 1'b0;
    wbs_dat_i = '0; wbs_ack_i = 1'b0;
    step(); step();
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_cyc_stb", 32'({wbs_cyc_o, wbs_stb_o}), 32'h0);
    chk("rst_resp", 32'(resp_now), 32'h0);
    rst_i = 1'b1;

    // I-only read, slave acks on cycle 3
    wbm_i_adr_i = 32'h1000_0040; wbm_i_cyc_i = 1'b1; wbm_i_stb_i = 1'b1;
    chk("t1_idle_first", 32'(grant_o), 32'h0);
    step();
    chk("t1_grant", 32'(grant_o), 32'h1);
    chk("t1_adr", wbs_adr_o, 32'h1000_0040);
    chk("t1_sel_we", 32'({wbs_sel_o, wbs_we_o}), 32'h6);
    chk("t1_cyc_stb", 32'({wbs_cyc_o, wbs_stb_o}), 32'h3);
    chk("t1_dat_o", 32'(wbs_dat_o), 32'h0);
    step();
    wbs_dat_i = 16'hBEEF; wbs_ack_i = 1'b1; push(R_ACK_I, 16'hBEEF);
    step();
    wbs_ack_i = 1'b0; wbm_i_cyc_i = 1'b0; wbm_i_stb_i = 1'b0;
    step();
    chk("t1_release", 32'(grant_o), 32'h0);

    // Tie after reset: D wins, then direct handover to I
    rst_i = 1'b0; step(); rst_i = 1'b1;
    wbm_d_adr_i = 32'h2000_0010; wbm_d_dat_i = 16'h1234; wbm_d_sel_i = 2'b10;
    wbm_d_we_i = 1'b1; wbm_d_cyc_i = 1'b1; wbm_d_stb_i = 1'b1;
    wbm_i_adr_i = 32'h1000_0080; wbm_i_cyc_i = 1'b1; wbm_i_stb_i = 1'b1;
    step();
    chk("t2_tie_d", 32'(grant_o), 32'h2);
    chk("t2_adr", wbs_adr_o, 32'h2000_0010);
    chk("t2_we_sel", 32'({wbs_we_o, wbs_sel_o}), 32'h6);
    chk("t2_dat_o", 32'(wbs_dat_o), 32'h1234);
    wbs_dat_i = 16'hC0DE; wbs_ack_i = 1'b1; push(R_ACK_D, 16'hC0DE);
    step();
    wbs_ack_i = 1'b0; wbm_d_cyc_i = 1'b0; wbm_d_stb_i = 1'b0; wbm_d_we_i = 1'b0;
    chk("t2_d_hold", 32'(grant_o), 32'h2);
    step();
    chk("t2_handover", 32'(grant_o), 32'h1);
    chk("t2_adr_i", wbs_adr_o, 32'h1000_0080);
    wbs_dat_i = 16'h5A5A; wbs_ack_i = 1'b1; push(R_ACK_I, 16'h5A5A);
    step();
    wbs_ack_i = 1'b0; wbm_i_cyc_i = 1'b0; wbm_i_stb_i = 1'b0;
    step();
    chk("t2_idle", 32'(grant_o), 32'h0);

    // D 4-beat burst while I waits (last owner I, so D wins the tie)
    wbm_d_adr_i = 32'h2000_0100; wbm_d_sel_i = 2'b11;
    wbm_d_cyc_i = 1'b1; wbm_d_stb_i = 1'b1;
    wbm_i_cyc_i = 1'b1; wbm_i_stb_i = 1'b1;
    step();
    chk("t3_grant_d", 32'(grant_o), 32'h2);
    for (int k = 0; k < 4; k++) begin
      wbs_dat_i = 16'hD000 + 16'(k); wbs_ack_i = 1'b1; push(R_ACK_D, 16'hD000 + 16'(k));
      chk("t3_beat_grant", 32'(grant_o), 32'h2);
      step();
      wbs_ack_i = 1'b0;
      chk("t3_gap_grant", 32'(grant_o), 32'h2);
      step();
    end
    wbm_d_cyc_i = 1'b0; wbm_d_stb_i = 1'b0;
    step();
    chk("t3_hand_i", 32'(grant_o), 32'h1);
    wbs_dat_i = 16'h1111; wbs_ack_i = 1'b1; push(R_ACK_I, 16'h1111);
    step();
    wbs_ack_i = 1'b0; wbm_i_cyc_i = 1'b0; wbm_i_stb_i = 1'b0;
    step();
    chk("t3_idle", 32'(grant_o), 32'h0);

    // Timeout: D strobes with no ack
    wbm_d_adr_i = 32'h2000_0200; wbm_d_cyc_i = 1'b1; wbm_d_stb_i = 1'b1;
    step();
    push(R_ERR_D, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      chk("t4_wait_grant", 32'(grant_o), 32'h2);
      step();
    end
    chk("t4_abort_grant", 32'(grant_o), 32'h0);
    chk("t4_abort_cyc", 32'(wbs_cyc_o), 32'h0);
    chk("t4_abort_err", 32'({wbm_i_err_o, wbm_d_err_o}), 32'h1);
    wbm_i_adr_i = 32'h1000_00C0; wbm_i_cyc_i = 1'b1; wbm_i_stb_i = 1'b1;
    step();
    chk("t4_abort_idle", 32'(grant_o), 32'h0);
    step();
    chk("t4_loser_i", 32'(grant_o), 32'h1);
    wbs_dat_i = 16'h7777; wbs_ack_i = 1'b1; push(R_ACK_I, 16'h7777);
    step();
    wbs_ack_i = 1'b0; wbm_i_cyc_i = 1'b0; wbm_i_stb_i = 1'b0;
    step();
    chk("t4_hand_d", 32'(grant_o), 32'h2);
    wbs_dat_i = 16'h8888; wbs_ack_i = 1'b1; push(R_ACK_D, 16'h8888);
    step();
    wbs_ack_i = 1'b0; wbm_d_cyc_i = 1'b0; wbm_d_stb_i = 1'b0;
    step();
    chk("t4_idle", 32'(grant_o), 32'h0);

    // Ack lands on the timeout cycle: ack wins, no abort
    wbm_d_cyc_i = 1'b1; wbm_d_stb_i = 1'b1;
    step(); step(); step(); step();
    wbs_dat_i = 16'h4242; wbs_ack_i = 1'b1; push(R_ACK_D, 16'h4242);
    step();
    chk("t5_ack_wins", 32'(grant_o), 32'h2);
    wbs_ack_i = 1'b0; wbm_d_cyc_i = 1'b0; wbm_d_stb_i = 1'b0;
    step();
    chk("t5_idle", 32'(grant_o), 32'h0);

    // Reset mid-transfer: no response, late ack dropped
    wbm_i_adr_i = 32'h1000_0100; wbm_i_cyc_i = 1'b1; wbm_i_stb_i = 1'b1;
    step(); step();
    chk("t6_owned", 32'(grant_o), 32'h1);
    rst_i = 1'b0;
    step();
    chk("t6_rst_grant", 32'(grant_o), 32'h0);
    chk("t6_rst_cyc", 32'(wbs_cyc_o), 32'h0);
    rst_i = 1'b1; wbm_i_cyc_i = 1'b0; wbm_i_stb_i = 1'b0;
    wbs_dat_i = 16'hDEAD; wbs_ack_i = 1'b1;
    chk("t6_late_ack", 32'(resp_now), 32'h0);
    step();
    wbs_ack_i = 1'b0;
    step(); step();

    done = 1'b1;
    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
